// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control and execute stages: function codes,
// FSM encodings and datapath width.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] F_SLL    = 6'b000000;
  localparam logic [5:0] F_SRL    = 6'b000010;
  localparam logic [5:0] F_SRA    = 6'b000011;
  localparam logic [5:0] F_CLZ    = 6'b000111;
  localparam logic [5:0] F_MFHI   = 6'b010000;
  localparam logic [5:0] F_MFLO   = 6'b010010;
  localparam logic [5:0] F_MULT   = 6'b011000;
  localparam logic [5:0] F_MULTU  = 6'b011001;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_SUBU   = 6'b100011;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_XOR    = 6'b100110;
  localparam logic [5:0] F_NOR    = 6'b100111;
  localparam logic [5:0] F_SLT    = 6'b101010;
  localparam logic [5:0] F_SLTU   = 6'b101011;
  localparam logic [5:0] F_BR_GTZ = 6'b110010;
  localparam logic [5:0] F_BR_AL  = 6'b110100;
  localparam logic [5:0] F_BR_LEZ = 6'b110110;
  localparam logic [5:0] F_CLO    = 6'b111000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  function automatic logic is_iter(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_CLO) || (f == F_CLZ);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: 32-step shift-add multiplier and leading-one/zero counter
// sharing one iteration counter. fin_o marks the last RUN cycle.
module alu_iter
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [5:0]         func_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               fin_o,
  output logic               is_mult_o,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [5:0]         count_o
);

  logic               run_q, mult_q, neg_q, tgt_q;
  logic [5:0]         cnt_q;
  logic [2*WIDTH-1:0] mcand_q, acc_q, sum;
  logic [WIDTH-1:0]   mplier_q, scan_q;
  logic               is_signed, a_neg, b_neg, scan_stop;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign is_signed = (func_i == F_MULT);
  assign a_neg     = is_signed && a_i[WIDTH-1];
  assign b_neg     = is_signed && b_i[WIDTH-1];
  assign mag_a     = a_neg ? (~a_i + 1'b1) : a_i;
  assign mag_b     = b_neg ? (~b_i + 1'b1) : b_i;

  assign sum       = acc_q + (mplier_q[0] ? mcand_q : '0);
  // All 32 bits matching needs one extra cycle to observe the exhausted scan.
  assign scan_stop = (cnt_q == 6'd32) || (scan_q[WIDTH-1] != tgt_q);
  assign fin_o     = run_q && (mult_q ? (cnt_q == 6'd31) : scan_stop);
  assign prod_o    = neg_q ? (~sum + 1'b1) : sum;
  assign count_o   = cnt_q;
  assign is_mult_o = mult_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      mult_q   <= 1'b0;
      neg_q    <= 1'b0;
      tgt_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      scan_q   <= '0;
    end else if (load_i) begin
      run_q    <= 1'b1;
      mult_q   <= (func_i == F_MULT) || (func_i == F_MULTU);
      neg_q    <= a_neg ^ b_neg;
      tgt_q    <= (func_i == F_CLO);
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, mag_a};
      acc_q    <= '0;
      mplier_q <= mag_b;
      scan_q   <= a_i;
    end else if (run_q) begin
      if (fin_o) begin
        run_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_q + 6'd1;
        acc_q    <= sum;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        scan_q   <= scan_q << 1;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops resolve at acceptance, MULT/CLO/CLZ run
// in alu_iter; results and flags are held until the next completion.
module alu_exec #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             cond,
  output logic             ovf
);
  import alu_pkg::*;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d, hi_q, lo_q, sum, diff, iter_res;
  logic               zero_q, cond_q, cond_d, ovf_q, ovf_d;
  logic               accept, iter_fin, iter_mult;
  logic [2*WIDTH-1:0] iter_prod;
  logic [5:0]         iter_count;

  assign accept   = (state_q == S_IDLE) && start;
  assign sum      = opA + opB;
  assign diff     = opA - opB;
  assign iter_res = iter_mult ? iter_prod[WIDTH-1:0] : WIDTH'(iter_count);

  alu_iter u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept && is_iter(func)),
    .func_i    (func),
    .a_i       (opA),
    .b_i       (opB),
    .fin_o     (iter_fin),
    .is_mult_o (iter_mult),
    .prod_o    (iter_prod),
    .count_o   (iter_count)
  );

  always_comb begin
    result_d = '0;
    cond_d   = 1'b0;
    ovf_d    = 1'b0;
    case (func)
      F_ADD: begin
        result_d = sum;
        ovf_d    = (opA[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != opA[WIDTH-1]);
      end
      F_SUB: begin
        result_d = diff;
        ovf_d    = (opA[WIDTH-1] != opB[WIDTH-1]) && (diff[WIDTH-1] != opA[WIDTH-1]);
      end
      F_ADDU:   result_d = sum;
      F_SUBU:   result_d = diff;
      F_AND:    result_d = opA & opB;
      F_OR:     result_d = opA | opB;
      F_XOR:    result_d = opA ^ opB;
      F_NOR:    result_d = ~(opA | opB);
      F_SLT:    result_d = WIDTH'($signed(opA) < $signed(opB));
      F_SLTU:   result_d = WIDTH'(opA < opB);
      F_SLL:    result_d = opB << opA[4:0];
      F_SRL:    result_d = opB >> opA[4:0];
      F_SRA:    result_d = WIDTH'($signed(opB) >>> opA[4:0]);
      F_MFHI:   result_d = hi_q;
      F_MFLO:   result_d = lo_q;
      F_BR_AL:  cond_d   = 1'b1;
      F_BR_GTZ: cond_d   = $signed(opA) > 0;
      F_BR_LEZ: cond_d   = $signed(opA) <= 0;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = is_iter(func) ? S_RUN : S_FIN;
      S_RUN:   if (iter_fin) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b0;
      cond_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Iterative ops leave the visible result untouched until they finish.
      if (accept && !is_iter(func)) begin
        result_q <= result_d;
        cond_q   <= cond_d;
        ovf_q    <= ovf_d;
        zero_q   <= (result_d == '0);
      end else if ((state_q == S_RUN) && iter_fin) begin
        result_q <= iter_res;
        cond_q   <= 1'b0;
        ovf_q    <= 1'b0;
        zero_q   <= (iter_res == '0);
        if (iter_mult) begin
          hi_q <= iter_prod[2*WIDTH-1:WIDTH];
          lo_q <= iter_prod[WIDTH-1:0];
        end
      end
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_FIN);
  assign result = result_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign zero   = zero_q;
  assign cond   = cond_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: stimulus pushes model predictions, a monitor
// pops and compares them whenever done is presented.
module tb_alu_exec;

  typedef struct {
    logic [31:0] r, hi, lo;
    logic        z, c, o;
    int          lat, cyc;
  } exp_t;

  logic        clk, rst_n, start;
  logic [5:0]  func;
  logic [31:0] opA, opB;
  logic        busy, done, zero, cond, ovf;
  logic [31:0] result, hi, lo;

  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  exp_t exq[$];
  exp_t me;
  logic [31:0] m_hi = 0, m_lo = 0;

  logic [5:0] codes [22] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                             6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                             6'b000000, 6'b000010, 6'b000011, 6'b010000, 6'b010010,
                             6'b110100, 6'b110010, 6'b110110, 6'b011000, 6'b011001,
                             6'b111000, 6'b000111};

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo),
    .zero(zero), .cond(cond), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour from the instruction semantics, using wide arithmetic.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    longint sa, sb, s, lmax, lmin;
    logic [63:0] p;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lmax = 2147483647;
    lmin = -lmax - 1;
    e.r = 0; e.c = 0; e.o = 0; e.lat = 1; e.cyc = 0;
    case (f)
      6'b100000: begin s = sa + sb; e.r = s[31:0]; e.o = (s > lmax) || (s < lmin); end
      6'b100010: begin s = sa - sb; e.r = s[31:0]; e.o = (s > lmax) || (s < lmin); end
      6'b100001: e.r = a + b;
      6'b100011: e.r = a - b;
      6'b100100: e.r = a & b;
      6'b100101: e.r = a | b;
      6'b100110: e.r = a ^ b;
      6'b100111: e.r = ~(a | b);
      6'b101010: e.r = (sa < sb) ? 32'd1 : 32'd0;
      6'b101011: e.r = (a < b) ? 32'd1 : 32'd0;
      6'b000000: e.r = b << a[4:0];
      6'b000010: e.r = b >> a[4:0];
      6'b000011: e.r = 32'($signed(b) >>> a[4:0]);
      6'b010000: e.r = m_hi;
      6'b010010: e.r = m_lo;
      6'b110100: e.c = 1'b1;
      6'b110010: e.c = (sa > 0);
      6'b110110: e.c = (sa <= 0);
      6'b011000, 6'b011001: begin
        if (f == 6'b011000) p = sa * sb;
        else p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
        e.r = m_lo;
        e.lat = 33;
      end
      6'b111000, 6'b000111: begin
        n = 0;
        for (int i = 31; i >= 0; i--) begin
          if (a[i] == (f == 6'b111000)) n++;
          else break;
        end
        e.r = n;
        e.lat = n + 2;
      end
      default: ;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    e.z  = (e.r == 0);
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    exp_t e;
    int n, bcnt;
    model(f, a, b, e);
    e.cyc = cyc + e.lat;
    exq.push_back(e);
    start = 1'b1; func = f; opA = a; opB = b;
    @(negedge clk);
    start = 1'b0; func = 6'($urandom); opA = $urandom; opB = $urandom;
    n = 0; bcnt = 0;
    while (!done && n < 40) begin
      if (busy) bcnt++;
      if (poke && n == 4) begin start = 1'b1; func = 6'b100000; end
      if (poke && n == 5) start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_seen f=%b", f), done, 1);
    chk($sformatf("busy_cycles f=%b", f), bcnt, e.lat - 1);
    $display("op func=%b a=%h b=%h exp_r=%h lat=%0d", f, a, b, e.r, e.lat);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_hi"}, hi, 0);
    chk({tag, "_lo"}, lo, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_zero"}, zero, 0);
    chk({tag, "_cond"}, cond, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exq.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        me = exq.pop_front();
        chk("result", result, me.r);
        chk("hi", hi, me.hi);
        chk("lo", lo, me.lo);
        chk("zero", zero, me.z);
        chk("cond", cond, me.c);
        chk("ovf", ovf, me.o);
        chk("done_cycle", cyc, me.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  f;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; func = 6'd0; opA = 0; opB = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(6'b100000, 32'h7FFFFFFF, 32'h1, 0);
    issue(6'b100001, 32'h7FFFFFFF, 32'h1, 0);
    issue(6'b100010, 32'h80000000, 32'h1, 0);
    issue(6'b011000, 32'hFFFFFFFD, 32'h7, 0);
    issue(6'b010010, $urandom, $urandom, 0);
    issue(6'b010000, $urandom, $urandom, 0);
    issue(6'b000111, 32'h00F00000, $urandom, 0);
    issue(6'b000111, 32'h0, $urandom, 0);
    issue(6'b111000, 32'hFFFFFFFF, $urandom, 0);
    issue(6'b000111, 32'h80000000, $urandom, 0);
    issue(6'b111000, 32'h0, $urandom, 0);
    issue(6'b110010, 32'h0, $urandom, 0);
    issue(6'b110110, 32'h0, $urandom, 0);
    issue(6'b110100, $urandom, $urandom, 0);
    issue(6'b111111, $urandom, $urandom, 0);
    issue(6'b011001, $urandom, $urandom, 1);
    issue(6'b011000, 32'h80000000, 32'h80000000, 0);

    // Abort a MULT at its tenth cycle, with a start offered on the reset edge.
    start = 1'b1; func = 6'b011000; opA = 32'hFFFFFFFD; opB = 32'h7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0; start = 1'b1; func = 6'b100000;
    @(negedge clk);
    start = 1'b0;
    chk_all_zero("abort");
    m_hi = 0; m_lo = 0;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(6'b010000, $urandom, $urandom, 0);

    for (int k = 0; k < 60; k++) begin
      f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 21)];
      a = $urandom;
      b = $urandom;
      if (f == 6'b000111) a = a >> $urandom_range(0, 32);
      if (f == 6'b111000) a = ~(a >> $urandom_range(0, 32));
      issue(f, a, b, 0);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port func  input  6  function code from the ALU control stage.
REQ-006 SHALL have ports opA, opB  input  WIDTH  operands (opA=rs, opB=rt/imm).
REQ-007 SHALL have port busy  output  1  iterative operation in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; result/flags valid from this cycle until the next accepted start.
REQ-009 SHALL have port result  output  WIDTH  registered result.
REQ-010 SHALL have ports hi, lo  output  WIDTH  multiply result registers.
REQ-011 SHALL have ports zero, cond, ovf  output  1 each  result==0, branch condition, signed overflow.

Function
REQ-012 SHALL use FSM states IDLE, RUN, FIN: IDLE->FIN on start with a single-cycle func; IDLE->RUN on start with func MULT/MULTU/CLO/CLZ; RUN->FIN on iteration end; FIN->IDLE unconditionally.
REQ-013 SHALL assert done only in FIN and busy only in RUN.
REQ-014 SHALL latch func, opA and opB on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-015 SHALL ignore start in RUN and FIN, with no queuing.
REQ-016 SHALL give single-cycle ops done exactly 1 cycle after the accepting edge.
REQ-017 SHALL implement the single-cycle ops: 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT (signed), 101011 SLTU, 000000 SLL, 000010 SRL, 000011 SRA (shift opB by opA[4:0]), 010000 MFHI, 010010 MFLO.
REQ-018 SHALL implement the branch compares on opA: 110100 (52) -> cond=1; 110010 (50) -> cond=(signed opA>0); 110110 (54) -> cond=(signed opA<=0); result SHALL be 0 for all three.
REQ-019 SHALL set ovf only for ADD/SUB signed overflow; result SHALL hold the wrapped sum and there SHALL be no trap.
REQ-020 SHALL use MULT 011000 (signed) and MULTU 011001: 32-iteration shift-add on magnitudes with sign fix-up for MULT; {hi,lo}=64-bit product; result=lo; done 33 cycles after acceptance.
REQ-021 SHALL use CLO 111000 and CLZ 000111: scan from bit 31 downward, one bit per cycle, stop at the first bit differing from the target; result = count (0..32); done count+2 cycles after acceptance, i.e. min 2 and max 34.
REQ-022 SHALL treat unknown func codes as single-cycle with result=0, cond=0, ovf=0.
REQ-023 SHALL change hi/lo only on completion of MULT/MULTU.
REQ-024 SHALL set zero from the registered result on every completion.
REQ-025 SHALL hold result, flags, hi and lo stable from done until the next completion.

Reset
REQ-026 SHALL, when rst_n=0 at a rising edge, force state=IDLE and busy, done, result, hi, lo, zero, cond, ovf all 0, regardless of state.
REQ-027 SHALL abort an in-flight operation on reset with no done, and SHALL ignore start on that edge.

Structure
REQ-028 SHALL place func code constants, FSM state encodings and WIDTH in a shared package alu_pkg, also used by the ALU control stage.
REQ-029 SHALL contain one sub-module, alu_iter, holding the multiply/count datapath and iteration counter; all remaining logic SHALL be in alu_exec.

Verification
REQ-030 SHALL check: ADD 0x7FFFFFFF+1 -> result 0x80000000, ovf=1, done 1 cycle after start; ADDU same operands -> ovf=0.
REQ-031 SHALL check: MULT opA=-3 (0xFFFFFFFD), opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done on cycle 33, busy high in cycles 1..32.
REQ-032 SHALL check: CLZ 0x00F00000 -> 8, done cycle 10; CLZ 0 -> 32, done cycle 34; CLO 0xFFFFFFFF -> 32.
REQ-033 SHALL check: func 50 with opA=0 -> cond=0; func 54 with opA=0 -> cond=1; func 52 -> cond=1 and result=0.
REQ-034 SHALL check: start pulsed mid-MULT -> ignored, product unchanged; rst_n low at cycle 10 of MULT -> no done, all outputs 0 next cycle, hi/lo=0.
REQ-035 SHALL check: MFLO after REQ-031 -> 0xFFFFFFEB; unknown func 111111 -> result 0, done after 1 cycle.
